// File: rtl/ttt_auto_player.sv
// rtl/ttt_auto_player.sv - tic-tac-toe move generator: win, then block, then fallback scan
module ttt_auto_player #(
    parameter logic [1:0] ME_CODE  = 2'b10,
    parameter logic [1:0] OPP_CODE = 2'b01
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       new_game,
    input  logic       turn_req,
    input  logic       opp_valid,
    input  logic [1:0] opp_row,
    input  logic [1:0] opp_col,
    output logic [1:0] move_row,
    output logic [1:0] move_col,
    output logic       move_strobe,
    output logic       busy,
    output logic       no_move,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLOCK, PICK, ISSUE} state_t;

    state_t          state, state_next;
    logic [3:0]      idx, idx_next;
    logic [8:0][1:0] board;
    logic            strobe_next, no_move_next;
    logic            pick_found;
    logic [3:0]      pick_idx;
    logic [3:0]      opp_k;
    logic            opp_bad, opp_occ;
    logic [3:0]      issue_rc;

    function automatic logic [11:0] line_cells(input logic [2:0] l);
        case (l)
            3'd0: return {4'd0, 4'd1, 4'd2};
            3'd1: return {4'd3, 4'd4, 4'd5};
            3'd2: return {4'd6, 4'd7, 4'd8};
            3'd3: return {4'd0, 4'd3, 4'd6};
            3'd4: return {4'd1, 4'd4, 4'd7};
            3'd5: return {4'd2, 4'd5, 4'd8};
            3'd6: return {4'd0, 4'd4, 4'd8};
            default: return {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    // True when cell k is empty and some line through k has its other two cells equal to c.
    function automatic logic completes(input logic [8:0][1:0] b, input logic [3:0] k,
                                       input logic [1:0] c);
        logic        hit;
        logic [11:0] ln;
        logic [3:0]  a0, a1, a2;
        hit = 1'b0;
        for (int l = 0; l < 8; l++) begin
            ln = line_cells(3'(l));
            a0 = ln[11:8];
            a1 = ln[7:4];
            a2 = ln[3:0];
            if (a0 == k && b[a1] == c && b[a2] == c) hit = 1'b1;
            if (a1 == k && b[a0] == c && b[a2] == c) hit = 1'b1;
            if (a2 == k && b[a0] == c && b[a1] == c) hit = 1'b1;
        end
        return hit && (b[k] == 2'b00);
    endfunction

    function automatic logic [3:0] cell_rc(input logic [3:0] k);
        case (k)
            4'd0: return {2'd0, 2'd0};
            4'd1: return {2'd0, 2'd1};
            4'd2: return {2'd0, 2'd2};
            4'd3: return {2'd1, 2'd0};
            4'd4: return {2'd1, 2'd1};
            4'd5: return {2'd1, 2'd2};
            4'd6: return {2'd2, 2'd0};
            4'd7: return {2'd2, 2'd1};
            4'd8: return {2'd2, 2'd2};
            default: return 4'd0;
        endcase
    endfunction

    assign opp_k    = ({2'b00, opp_row} * 4'd3) + {2'b00, opp_col};
    assign opp_bad  = (opp_row == 2'd3) || (opp_col == 2'd3);
    assign opp_occ  = !opp_bad && (board[opp_k] != 2'b00);
    assign issue_rc = cell_rc(idx);

    // Center first, otherwise the lowest empty cell.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 4'd0;
        if (board[4] == 2'b00) begin
            pick_found = 1'b1;
            pick_idx   = 4'd4;
        end else begin
            for (int i = 8; i >= 0; i--) begin
                if (board[i] == 2'b00) begin
                    pick_found = 1'b1;
                    pick_idx   = 4'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            idx   <= 4'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        strobe_next  = 1'b0;
        no_move_next = 1'b0;
        case (state)
            IDLE: begin
                if (turn_req) begin
                    idx_next   = 4'd0;
                    state_next = SCAN_WIN;
                end
            end
            SCAN_WIN: begin
                if (completes(board, idx, ME_CODE)) begin
                    state_next = ISSUE;
                end else if (idx == 4'd8) begin
                    idx_next   = 4'd0;
                    state_next = SCAN_BLOCK;
                end else begin
                    idx_next = idx + 4'd1;
                end
            end
            SCAN_BLOCK: begin
                if (completes(board, idx, OPP_CODE)) begin
                    state_next = ISSUE;
                end else if (idx == 4'd8) begin
                    state_next = PICK;
                end else begin
                    idx_next = idx + 4'd1;
                end
            end
            PICK: begin
                if (pick_found) begin
                    idx_next   = pick_idx;
                    state_next = ISSUE;
                end else begin
                    no_move_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            ISSUE: begin
                strobe_next = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (new_game) begin
            state_next   = IDLE;
            strobe_next  = 1'b0;
            no_move_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            board       <= '0;
            move_row    <= 2'd0;
            move_col    <= 2'd0;
            move_strobe <= 1'b0;
            no_move     <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            move_strobe <= strobe_next;
            no_move     <= no_move_next;
            err         <= 1'b0;
            busy        <= (state != IDLE);
            if (new_game) begin
                board <= '0;
                busy  <= 1'b0;
            end else begin
                if (opp_valid) begin
                    if (opp_bad || opp_occ || state != IDLE) err <= 1'b1;
                    if (!opp_bad && !opp_occ) board[opp_k] <= OPP_CODE;
                end
                // Own write is last so it wins a same-cell collision with the opponent.
                if (state == ISSUE) begin
                    board[idx] <= ME_CODE;
                    move_row   <= issue_rc[3:2];
                    move_col   <= issue_rc[1:0];
                end
            end
        end
    end

endmodule

// File: doc/ttt_auto_player.md
Name: ttt_auto_player

Overview:
Automatic move generator that drives the move side of the tic-tac-toe game controller in place of a human player. It keeps its own 3x3 board copy from opponent moves and its own issued moves. On each turn request it scans for a winning move, then a blocking move, then a fallback. It emits a row/column pair with a one-cycle strobe, matching the player move-strobe convention of the game controller.

Parameters:
ME_CODE, 2'b10, cell code written for this player's moves.
OPP_CODE, 2'b01, cell code written for opponent moves.

Ports:
clk  input  1  system clock, rising edge.
resetn  input  1  asynchronous active-low reset.
new_game  input  1  synchronous clear of board copy; returns FSM to IDLE; overrides all other inputs.
turn_req  input  1  level; sampled in IDLE only; requests one move.
opp_valid  input  1  one-cycle pulse; opponent placed a mark at opp_row/opp_col.
opp_row  input  2  opponent row, 0..2.
opp_col  input  2  opponent column, 0..2.
move_row  output  2  chosen row; holds last value.
move_col  output  2  chosen column; holds last value.
move_strobe  output  1  one-cycle pulse; move_row/move_col are valid.
busy  output  1  high in every state except IDLE.
no_move  output  1  one-cycle pulse; board full, no move issued.
err  output  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset (async, resetn=0):
  - all board cells = 2'b00; FSM = IDLE; scan index = 0.
  - move_row = move_col = 0; move_strobe = no_move = err = busy = 0.
- Cell index k = 0..8 maps to row = k/3, col = k%3.
- Lines checked: 3 rows, 3 columns, 2 diagonals.
- completes(k, C) is true when cell k is empty and, for some line through k, both other cells equal C.
- FSM states:
  - IDLE: if turn_req, set idx = 0 and go to SCAN_WIN.
  - SCAN_WIN: one cell per cycle. If completes(idx, ME_CODE), latch idx and go to ISSUE. Else if idx = 8, set idx = 0 and go to SCAN_BLOCK. Else idx + 1.
  - SCAN_BLOCK: same as SCAN_WIN but tests completes(idx, OPP_CODE).
  - PICK: choose center (k=4) if empty, else the lowest empty index. Latch it and go to ISSUE. If no cell is empty, pulse no_move and go to IDLE.
  - ISSUE: drive move_row/move_col from the latched idx, assert move_strobe for exactly 1 cycle, write ME_CODE to that cell, go to IDLE.
- Latency, with turn_req sampled at edge 0:
  - win at cell k: strobe in cycle k+2.
  - block at cell k: strobe in cycle k+11.
  - fallback: strobe in cycle 20.
  - board full: no_move in cycle 19.
- Opponent update: on opp_valid, write OPP_CODE to [opp_row][opp_col] if that cell is empty.
- err pulses one cycle after any of these:
  - opp_valid targets an occupied cell (board unchanged);
  - opp_row or opp_col equals 3 (ignored);
  - opp_valid arrives while busy. The write still applies, and the current scan continues on the updated board.
- opp_valid in the same cycle as ISSUE, same cell: the own write wins and err pulses. Different cells: both writes apply.
- new_game in any state:
  - clears the board, forces IDLE next cycle, and suppresses move_strobe/no_move that cycle;
  - an opp_valid in the same cycle is discarded.
- turn_req held high after ISSUE returns to IDLE: a new request starts; the level is not edge-detected.
- The block neither tracks the game result nor gates on it. The game controller owns win/draw decisions.

Test Plan:
- Reset, opp_valid (0,0), then turn_req → no win or block found; center chosen; move_row=1, move_col=1, strobe 20 cycles after the sampling edge.
- Own marks at (0,0),(0,1) via prior ISSUEs, opponent at (1,0),(1,1), turn_req → win at k=2; move=(0,2), strobe in cycle 4.
- Opponent at (0,0),(1,1), own at (0,1), turn_req → no win; block at k=8; move=(2,2), strobe in cycle 19.
- Opponent 5 marks and own 4 marks, board full, turn_req → no_move pulse in cycle 19; move_strobe stays 0; busy falls next cycle.
- opp_valid on an occupied cell, then opp_row=3, then opp_valid during SCAN_WIN → err pulses 3 times; board content checked via the subsequent move choice.
- resetn asserted mid-SCAN_BLOCK and new_game asserted mid-SCAN_WIN → outputs take reset values immediately / next cycle; board empty (next turn_req yields center (1,1)).
